cam_capture_param: RTL and testbench

//  Parametrised DVP camera capture front end. Packs sensor bytes (vsync/href/d)

---
 rtl/cam_cap_pkg.sv | 34 +++
 rtl/cam_byte_pack.sv | 85 ++++++++
 rtl/cam_capture_param.sv | 154 +++++++++++++++
 tb/tb_cam_capture_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cap_pkg.sv
// cam_cap_pkg
//   Shared definitions for the DVP camera capture block: the capture FSM
//   state encoding and the helpers that derive the stored image size from
//   the sensor image size.
//   Configuration macro: CAM_CAPTURE_DECIMATE_EN (defined = 2x decimation,
//   stored image is half the sensor size in each direction).
package cam_cap_pkg;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2,
    S_SKIP   = 2'd3
  } cap_state_t;

  // Stored pixels per line for a given sensor line width.
  function automatic int out_w(input int img_w);
`ifdef CAM_CAPTURE_DECIMATE_EN
    return img_w / 2;
`else
    return img_w;
`endif
  endfunction

  // Stored lines per frame for a given sensor frame height.
  function automatic int out_h(input int img_h);
`ifdef CAM_CAPTURE_DECIMATE_EN
    return img_h / 2;
`else
    return img_h;
`endif
  endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// cam_byte_pack
//   Assembles sensor bytes into pixels and detects line ends.
//   Ports:
//     pclk, rst    pixel clock, asynchronous active-high reset
//     enable       bytes are only taken while high (capturing, vsync low)
//     href, d      sensor line-valid and data byte
//     pix_valid    one-cycle pulse, pix_data holds a complete pixel
//     pix_data     packed pixel, first byte in the MSBs
//     line_end     one-cycle pulse after the last byte of a line
//     partial      valid with line_end: the line stopped mid-pixel
module cam_byte_pack
  import cam_cap_pkg::*;
#(
  parameter int BYTES_PER_PIX = 2
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         href,
  input  logic [7:0]                   d,
  output logic                         pix_valid,
  output logic [8*BYTES_PER_PIX-1:0]   pix_data,
  output logic                         line_end,
  output logic                         partial
);

  logic take;
  logic phase;
  logic in_line;
  logic pix_done;
  logic [8*BYTES_PER_PIX-1:0] next_data;

  assign take = enable && href;

  // Two-byte pixels latch the first byte and complete on the second.
  if (BYTES_PER_PIX == 2) begin : g_two
    logic [7:0] first_byte;

    always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
        first_byte <= 8'd0;
      end else if (take && !phase) begin
        first_byte <= d;
      end
    end

    assign next_data = {first_byte, d};
    assign pix_done  = take && phase;
  end else begin : g_one
    assign next_data = d;
    assign pix_done  = take;
  end

  // A line ends when bytes stop arriving, either by href falling or by the
  // capture window closing (vsync rising mid-line). Any half-built pixel is
  // dropped and reported through partial.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      in_line   <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      line_end  <= 1'b0;
      partial   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      line_end  <= 1'b0;
      partial   <= 1'b0;
      if (take) begin
        in_line <= 1'b1;
        phase   <= (BYTES_PER_PIX == 2) && !phase;
        if (pix_done) begin
          pix_valid <= 1'b1;
          pix_data  <= next_data;
        end
      end else if (in_line) begin
        in_line  <= 1'b0;
        line_end <= 1'b1;
        partial  <= phase;
        phase    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_capture_param.sv
// cam_capture_param
//   DVP camera capture front end: packs sensor bytes into pixels and writes
//   them to a frame buffer at row-aligned addresses, with frame gating and
//   sticky line/overflow error flags.
//   Configuration macro: CAM_CAPTURE_DECIMATE_EN (store only even-x pixels
//   of even-y lines; stored image is IMG_W/2 x IMG_H/2).
//   Ports:
//     pclk, rst        pixel clock, asynchronous active-high reset
//     vsync, href, d   sensor frame sync, line valid, data byte
//     cap_en           capture enable, sampled when vsync falls
//     addr, dout, we   frame-buffer write port (one write per pclk max)
//     wclk             pclk forwarded to the buffer
//     frame_done       one-cycle pulse at the end of a captured frame
//     line_err         sticky, a line ended with a partial pixel
//     ovf_err          sticky, pixels or lines beyond IMG_W/IMG_H seen
module cam_capture_param
  import cam_cap_pkg::*;
#(
  parameter int IMG_W         = 320,
  parameter int IMG_H         = 240,
  parameter int BYTES_PER_PIX = 2,
  parameter int ADDR_W        = 17
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         vsync,
  input  logic                         href,
  input  logic [7:0]                   d,
  input  logic                         cap_en,
  output logic [ADDR_W-1:0]            addr,
  output logic [8*BYTES_PER_PIX-1:0]   dout,
  output logic                         we,
  output logic                         wclk,
  output logic                         frame_done,
  output logic                         line_err,
  output logic                         ovf_err
);

  localparam int OUT_W = out_w(IMG_W);
  localparam int XW    = $clog2(IMG_W + 1);
  localparam int YW    = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_LIM = XW'(IMG_W);
  localparam logic [YW-1:0] Y_LIM = YW'(IMG_H);

  cap_state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] pix_addr;
  logic pack_en, pix_valid, line_end, partial;
  logic in_range, keep, adv;
  logic [8*BYTES_PER_PIX-1:0] pix_data;

  assign wclk     = pclk;
  assign pack_en  = (state == S_ACTIVE) && !vsync;
  assign in_range = (x < X_LIM) && (y < Y_LIM);

  // row_base stops advancing once the last stored row is reached, so the
  // address can never point past the end of the buffer.
`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam logic [YW-1:0] Y_ADV = YW'(IMG_H - 2);
  assign keep     = !x[0] && !y[0];
  assign adv      = !y[0] && (y < Y_ADV);
  assign pix_addr = row_base + ADDR_W'(x >> 1);
`else
  localparam logic [YW-1:0] Y_ADV = YW'(IMG_H - 1);
  assign keep     = 1'b1;
  assign adv      = (y < Y_ADV);
  assign pix_addr = row_base + ADDR_W'(x);
`endif

  cam_byte_pack #(
    .BYTES_PER_PIX(BYTES_PER_PIX)
  ) u_pack (
    .pclk     (pclk),
    .rst      (rst),
    .enable   (pack_en),
    .href     (href),
    .d        (d),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .line_end (line_end),
    .partial  (partial)
  );

  // Frame FSM plus position counters. Entry into the first capture always
  // goes through S_VBLANK, so a frame already in progress at reset is never
  // stored.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= S_SYNC;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_SYNC: begin
          if (vsync) state <= S_VBLANK;
        end
        S_VBLANK: begin
          x        <= '0;
          y        <= '0;
          row_base <= '0;
          if (!vsync) begin
            if (cap_en) begin
              state    <= S_ACTIVE;
              line_err <= 1'b0;
              ovf_err  <= 1'b0;
            end else begin
              state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (vsync) state <= S_VBLANK;
        end
        S_ACTIVE: begin
          if (vsync) begin
            frame_done <= 1'b1;
            state      <= S_VBLANK;
          end
          if (pix_valid) begin
            if (!in_range) begin
              ovf_err <= 1'b1;
            end else begin
              x <= x + XW'(1);
              if (keep) begin
                we   <= 1'b1;
                addr <= pix_addr;
                dout <= pix_data;
              end
            end
          end
          if (line_end) begin
            x <= '0;
            if (y < Y_LIM) y <= y + YW'(1);
            if (adv) row_base <= row_base + ADDR_W'(OUT_W);
          end
        end
        default: state <= S_SYNC;
      endcase
      if (line_end && partial) line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture_param.sv
// tb_cam_capture_param
//   Directed bench for cam_capture_param with a 4-pixel-wide RGB565 image.
//   A monitor logs every write and frame_done pulse; each scenario compares
//   the log and the error flags against hand-derived values.
module tb_cam_capture_param;

  localparam int IMG_W = 4;
`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam int IMG_H = 4;
`else
  localparam int IMG_H = 2;
`endif
  localparam int BPP    = 2;
  localparam int ADDR_W = 17;

  logic              pclk = 1'b0;
  logic              rst;
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic              cap_en;
  logic [ADDR_W-1:0] addr;
  logic [8*BPP-1:0]  dout;
  logic              we;
  logic              wclk;
  logic              frame_done;
  logic              line_err;
  logic              ovf_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_count     = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always #5 pclk = ~pclk;

  cam_capture_param #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .BYTES_PER_PIX(BPP),
    .ADDR_W(ADDR_W)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .cap_en    (cap_en),
    .addr      (addr),
    .dout      (dout),
    .we        (we),
    .wclk      (wclk),
    .frame_done(frame_done),
    .line_err  (line_err),
    .ovf_err   (ovf_err)
  );

  // Write/frame_done logger, sampled on the inactive edge.
  always @(negedge pclk) begin
    if (we) begin
      wr_addr.push_back(32'(addr));
      wr_data.push_back(32'(dout));
    end
    if (frame_done) fd_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    d    = b;
    tick(1);
  endtask

  task automatic end_line();
    href = 1'b0;
    d    = 8'h00;
    tick(3);
  endtask

  // One sensor line of n bytes counting up from base.
  task automatic applyStimulus(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
    end_line();
  endtask

  task automatic frame_start(input logic en);
    vsync = 1'b1;
    tick(3);
    cap_en = en;
    vsync  = 1'b0;
    tick(2);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    tick(3);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    fd_count = 0;
  endtask

  task automatic check_write(input string tag, input int i, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] a;
    logic [31:0] v;
    a = (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFF_FFFF;
    v = (i < wr_data.size()) ? wr_data[i] : 32'hFFFF_FFFF;
    checkOutput({tag, "_addr"}, a, ea);
    checkOutput({tag, "_data"}, v, ed);
  endtask

`ifdef CAM_CAPTURE_DECIMATE_EN
  logic [31:0] exp6_data [4] = '{32'h100F, 32'h120F, 32'h300F, 32'h320F};
`endif

  initial begin
    rst    = 1'b1;
    vsync  = 1'b0;
    href   = 1'b0;
    d      = 8'h00;
    cap_en = 1'b0;
    tick(3);
    checkOutput("rst_addr", 32'(addr), 32'h0);
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_we", 32'(we), 32'h0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    checkOutput("rst_line_err", 32'(line_err), 32'h0);
    checkOutput("rst_ovf_err", 32'(ovf_err), 32'h0);
    checkOutput("wclk_follows_pclk", 32'(wclk), 32'(pclk));
    rst = 1'b0;
    tick(2);
    clear_log();

`ifdef CAM_CAPTURE_DECIMATE_EN
    // 4x4 image, pixel (x,y) = {16*(y+1)+x, 0x0F}
    frame_start(1'b1);
    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 0; xx < 4; xx++) begin
        send_byte(8'(16 * (yy + 1) + xx));
        send_byte(8'h0F);
      end
      end_line();
    end
    frame_end();
    checkOutput("t6_writes", 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_write("t6", i, 32'(i), exp6_data[i]);
    checkOutput("t6_frame_done", 32'(fd_count), 32'd1);
    checkOutput("t6_line_err", 32'(line_err), 32'h0);
    checkOutput("t6_ovf_err", 32'(ovf_err), 32'h0);
`else
    // Frame in progress at reset is dropped; next frame stored.
    applyStimulus(8, 8'h01);
    applyStimulus(8, 8'h09);
    checkOutput("t1_drop_writes", 32'(wr_addr.size()), 32'd0);
    frame_start(1'b1);
    applyStimulus(8, 8'h01);
    applyStimulus(8, 8'h09);
    frame_end();
    checkOutput("t1_writes", 32'(wr_addr.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      check_write("t1", k, 32'(k), 32'((2 * k + 1) * 256 + (2 * k + 2)));
    checkOutput("t1_frame_done", 32'(fd_count), 32'd1);
    checkOutput("t1_line_err", 32'(line_err), 32'h0);
    checkOutput("t1_ovf_err", 32'(ovf_err), 32'h0);

    // 7-byte line: 3 pixels, partial dropped, next line at row_base.
    clear_log();
    frame_start(1'b1);
    applyStimulus(7, 8'h20);
    checkOutput("t2_line_err", 32'(line_err), 32'h1);
    applyStimulus(8, 8'h30);
    frame_end();
    checkOutput("t2_writes", 32'(wr_addr.size()), 32'd7);
    check_write("t2_w0", 0, 32'd0, 32'h2021);
    check_write("t2_w2", 2, 32'd2, 32'h2425);
    check_write("t2_w3", 3, 32'd4, 32'h3031);
    check_write("t2_w6", 6, 32'd7, 32'h3637);
    checkOutput("t2_line_err_sticky", 32'(line_err), 32'h1);

    // 6-pixel line on a 4-wide image: overflow.
    clear_log();
    frame_start(1'b1);
    checkOutput("t3_line_err_cleared", 32'(line_err), 32'h0);
    applyStimulus(12, 8'h40);
    checkOutput("t3_ovf_err", 32'(ovf_err), 32'h1);
    applyStimulus(8, 8'h70);
    frame_end();
    checkOutput("t3_writes", 32'(wr_addr.size()), 32'd8);
    check_write("t3_w3", 3, 32'd3, 32'h4647);
    check_write("t3_w4", 4, 32'd4, 32'h7071);
    check_write("t3_w7", 7, 32'd7, 32'h7677);

    // cap_en low: frame skipped, errors untouched.
    clear_log();
    frame_start(1'b0);
    applyStimulus(8, 8'h50);
    applyStimulus(8, 8'h58);
    frame_end();
    checkOutput("t4_skip_writes", 32'(wr_addr.size()), 32'd0);
    checkOutput("t4_skip_frame_done", 32'(fd_count), 32'd0);
    checkOutput("t4_skip_ovf_kept", 32'(ovf_err), 32'h1);

    // cap_en high again: normal capture, ovf_err cleared.
    clear_log();
    frame_start(1'b1);
    checkOutput("t4_ovf_cleared", 32'(ovf_err), 32'h0);
    applyStimulus(8, 8'h60);
    applyStimulus(8, 8'h68);
    frame_end();
    checkOutput("t4_writes", 32'(wr_addr.size()), 32'd8);
    check_write("t4_w0", 0, 32'd0, 32'h6061);
    check_write("t4_w7", 7, 32'd7, 32'h6E6F);
    checkOutput("t4_frame_done", 32'(fd_count), 32'd1);

    // Reset pulse mid-line.
    frame_start(1'b1);
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    checkOutput("t5_we_before", 32'(we), 32'h1);
    checkOutput("t5_dout_before", 32'(dout), 32'hA0A1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_we_async", 32'(we), 32'h0);
    checkOutput("t5_dout_async", 32'(dout), 32'h0);
    tick(2);
    rst = 1'b0;
    clear_log();
    send_byte(8'hA3);
    send_byte(8'hA4);
    send_byte(8'hA5);
    end_line();
    applyStimulus(8, 8'hB0);
    checkOutput("t5_no_writes", 32'(wr_addr.size()), 32'd0);
    frame_start(1'b1);
    applyStimulus(8, 8'h50);
    frame_end();
    checkOutput("t5_writes", 32'(wr_addr.size()), 32'd4);
    check_write("t5_w0", 0, 32'd0, 32'h5051);
    check_write("t5_w3", 3, 32'd3, 32'h5657);
    checkOutput("t5_frame_done", 32'(fd_count), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
